srl_fifo_flex: RTL and testbench
================================

Name: srl_fifo_flex

Overview:
- Parametrised shift-register FIFO for HLS dataflow channels (start tokens and stream data between PE stages).
- Generalises the fixed-depth addressed shift register into a complete FIFO: occupancy tracking, ap_fifo-style full/empty handshakes, almost-full/almost-empty flags, and an optional registered first-word-fall-through output stage for timing closure.
- Storage is an SRL-inferable shift array addressed by occupancy.

Parameters:
- DATA_WIDTH, 32, payload width in bits (>=1).
- ADDR_WIDTH, 4, address width of the shift array; DEPTH <= 2**ADDR_WIDTH.
- DEPTH, 16, shift-array capacity in words (>=2).
- OUT_REG, 0, 0 = combinational read from the array; 1 = registered output stage, adding one word of capacity.
- AFULL_THRESH, 14, if_almost_full asserts when if_num_data_valid >= this value.
- AEMPTY_THRESH, 1, if_almost_empty asserts when if_num_data_valid <= this value.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- if_full_n  out  1  1 = the shift array can accept a word.
- if_write_ce  in  1  write clock-enable.
- if_write  in  1  write request.
- if_din  in  DATA_WIDTH  write data.
- if_empty_n  out  1  1 = if_dout is valid.
- if_read_ce  in  1  read clock-enable.
- if_read  in  1  read request (acknowledges the current if_dout).
- if_dout  out  DATA_WIDTH  head-of-FIFO data.
- if_num_data_valid  out  ADDR_WIDTH+1  total words held, including the output register.
- if_almost_full  out  1  occupancy >= AFULL_THRESH.
- if_almost_empty  out  1  occupancy <= AEMPTY_THRESH.

Behaviour:
- push = if_write_ce & if_write & if_full_n.
- pop = if_read_ce & if_read & if_empty_n.
- Requests are ignored when the corresponding flag is low; there is no overflow or underflow.
- Shift array:
  - Updates only when it receives a push.
  - On a push, element i moves to i+1 and if_din enters index 0.
  - The array has no reset; contents survive reset but are logically discarded.
- scnt (shift-array occupancy, 0..DEPTH):
  - Increments on push without shift-pop; decrements on shift-pop without push; otherwise holds.
  - Head address = scnt-1, or 0 when scnt = 0.
- if_full_n is registered: 1 when the next scnt < DEPTH.

OUT_REG=0:
- shift-pop = pop; if_empty_n is registered (next scnt != 0); if_dout = array[head address].
- if_num_data_valid = scnt.
- Latency: a push at edge N gives if_empty_n=1 after edge N.
- Simultaneous push and pop: scnt unchanged, head address unchanged, the next word is presented.
- At full, only a pop is possible. At empty, only a push is possible; there is no bypass.

OUT_REG=1:
- Output register dreg with valid flag oval; if_empty_n = oval; if_dout = dreg.
- load = (scnt != 0) & (!oval | pop). On load, dreg <= array[head address] and a shift-pop is performed.
- oval becomes 1 on load; it becomes 0 on pop without load; otherwise it holds.
- if_num_data_valid = scnt + oval; maximum DEPTH+1.
- Latency: a push at edge N loads dreg at edge N+1, so if_empty_n=1 after edge N+1.
- Back-to-back pops stream one word per cycle while scnt > 0.
- if_full_n depends on scnt only.

Reset (synchronous, takes priority over push and pop in the same cycle):
- After the reset edge: scnt=0, oval=0, if_full_n=1, if_empty_n=0, if_num_data_valid=0, if_almost_full=0, if_almost_empty=1 (for AEMPTY_THRESH >= 0).
- Reset mid-stream discards all words.
- if_dout is unspecified while if_empty_n=0.

Almost flags:
- Combinational from the registered if_num_data_valid.
- Thresholds are compared as unsigned values of width ADDR_WIDTH+1.

Test Plan:
- OUT_REG=0, DEPTH=4: push 0x11,0x22,0x33,0x44 on consecutive cycles -> if_full_n=0 after the 4th push. A 5th push with 0x55 is ignored. Popping 4 words returns 0x11..0x44 in order, then if_empty_n=0 and count=0.
- OUT_REG=0, hold 2 words, then push and pop every cycle for 20 cycles with an incrementing pattern -> count stays at 2, output is in order with no gaps, if_full_n=1 throughout.
- Gating: if_write=1 with if_write_ce=0, and if_read=1 with if_read_ce=0, for 5 cycles -> no change to count, flags or if_dout.
- Reset mid-stream: 3 words held, assert reset for 1 cycle together with push and pop -> count=0, if_empty_n=0, if_full_n=1. The next push of 0xA5 reads back as 0xA5.
- OUT_REG=1, DEPTH=4: single push at edge N -> if_empty_n rises after edge N+1. Five pushes fill the FIFO (count=5, if_full_n=0 with scnt=4). Five consecutive pops drain it in order at one word per cycle.
- AFULL_THRESH=3, AEMPTY_THRESH=1: step occupancy 0->4->0 -> if_almost_full asserts at count 3 and 4; if_almost_empty asserts at count 0 and 1.

Source files
------------

// File: rtl/srl_fifo_flex.sv
// Shift-register FIFO for HLS dataflow channels: SRL storage addressed by occupancy,
// registered full/empty handshakes, almost flags and an optional registered output stage.
module srl_fifo_flex #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDR_WIDTH    = 4,
  parameter int unsigned DEPTH         = 16,
  parameter int unsigned OUT_REG       = 0,
  parameter int unsigned AFULL_THRESH  = 14,
  parameter int unsigned AEMPTY_THRESH = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  if_full_n,
  input  logic                  if_write_ce,
  input  logic                  if_write,
  input  logic [DATA_WIDTH-1:0] if_din,
  output logic                  if_empty_n,
  input  logic                  if_read_ce,
  input  logic                  if_read,
  output logic [DATA_WIDTH-1:0] if_dout,
  output logic [ADDR_WIDTH:0]   if_num_data_valid,
  output logic                  if_almost_full,
  output logic                  if_almost_empty
);

  localparam int unsigned CW = ADDR_WIDTH + 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [CW-1:0]         scnt_q, scnt_d;
  logic                  full_n_q, full_n_d;
  logic                  empty_n_q, empty_n_d;
  logic                  oval_q, oval_d;
  logic [DATA_WIDTH-1:0] dreg_q;
  logic [ADDR_WIDTH-1:0] head;
  logic                  push, pop, spop, load;

  assign push = if_write_ce & if_write & full_n_q;
  assign pop  = if_read_ce & if_read & if_empty_n;
  assign head = (scnt_q == '0) ? '0 : ADDR_WIDTH'(scnt_q - CW'(1));

  always_comb begin
    load = 1'b0;
    spop = pop;
    // With the output stage, the array is popped whenever a word moves into dreg.
    if (OUT_REG != 0) begin
      load = (scnt_q != '0) && (!oval_q || pop);
      spop = load;
    end
    scnt_d = scnt_q;
    if (push && !spop)
      scnt_d = scnt_q + CW'(1);
    else if (!push && spop)
      scnt_d = scnt_q - CW'(1);
    full_n_d  = scnt_d < CW'(DEPTH);
    empty_n_d = scnt_d != '0;
    oval_d    = oval_q;
    if (load)
      oval_d = 1'b1;
    else if (pop)
      oval_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      scnt_q    <= '0;
      full_n_q  <= 1'b1;
      empty_n_q <= 1'b0;
      oval_q    <= 1'b0;
    end else begin
      scnt_q    <= scnt_d;
      full_n_q  <= full_n_d;
      empty_n_q <= empty_n_d;
      oval_q    <= oval_d;
    end
  end

  // Storage and dreg carry no reset so the array maps onto SRL primitives.
  always_ff @(posedge clk) begin
    if (push) begin
      for (int unsigned i = DEPTH - 1; i > 0; i--)
        mem_q[i] <= mem_q[i-1];
      mem_q[0] <= if_din;
    end
  end

  always_ff @(posedge clk) begin
    if (load)
      dreg_q <= mem_q[head];
  end

  assign if_full_n         = full_n_q;
  assign if_empty_n        = (OUT_REG != 0) ? oval_q : empty_n_q;
  assign if_dout           = (OUT_REG != 0) ? dreg_q : mem_q[head];
  assign if_num_data_valid = (OUT_REG != 0) ? scnt_q + CW'(oval_q) : scnt_q;
  assign if_almost_full    = if_num_data_valid >= CW'(AFULL_THRESH);
  assign if_almost_empty   = if_num_data_valid <= CW'(AEMPTY_THRESH);

endmodule

// File: tb/tb_srl_fifo_flex.sv
// Bench for srl_fifo_flex: directed vector table, hand-written corner sequences and
// randomized traffic against a queue-based reference, on OUT_REG=0 and OUT_REG=1 instances.
module tb_srl_fifo_flex;

  localparam int DW = 8;
  localparam int AW = 2;
  localparam int DP = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, sel;
  logic          wce, w, rce, r;
  logic [DW-1:0] din;
  logic          rst0, rst1;

  logic          full_n0, empty_n0, af0, ae0;
  logic          full_n1, empty_n1, af1, ae1;
  logic [DW-1:0] dout0, dout1;
  logic [AW:0]   cnt0, cnt1;

  // The idle instance is held in reset so shared stimulus cannot disturb it.
  assign rst0 = sel ? 1'b1 : rst;
  assign rst1 = sel ? rst : 1'b1;

  srl_fifo_flex #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DP), .OUT_REG(0),
                  .AFULL_THRESH(3), .AEMPTY_THRESH(1)) u_dut0 (
    .clk(clk), .reset(rst0), .if_full_n(full_n0), .if_write_ce(wce), .if_write(w),
    .if_din(din), .if_empty_n(empty_n0), .if_read_ce(rce), .if_read(r), .if_dout(dout0),
    .if_num_data_valid(cnt0), .if_almost_full(af0), .if_almost_empty(ae0));

  srl_fifo_flex #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DP), .OUT_REG(1),
                  .AFULL_THRESH(3), .AEMPTY_THRESH(1)) u_dut1 (
    .clk(clk), .reset(rst1), .if_full_n(full_n1), .if_write_ce(wce), .if_write(w),
    .if_din(din), .if_empty_n(empty_n1), .if_read_ce(rce), .if_read(r), .if_dout(dout1),
    .if_num_data_valid(cnt1), .if_almost_full(af1), .if_almost_empty(ae1));

  logic          o_full_n, o_empty_n, o_af, o_ae;
  logic [DW-1:0] o_dout;
  logic [AW:0]   o_cnt;
  assign o_full_n  = sel ? full_n1  : full_n0;
  assign o_empty_n = sel ? empty_n1 : empty_n0;
  assign o_af      = sel ? af1      : af0;
  assign o_ae      = sel ? ae1      : ae0;
  assign o_dout    = sel ? dout1    : dout0;
  assign o_cnt     = sel ? cnt1     : cnt0;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rs, input logic wc, input logic wr, input logic [DW-1:0] d,
                       input logic rc, input logic rd);
    rst = rs; wce = wc; w = wr; din = d; rce = rc; r = rd;
  endtask

  typedef struct {
    logic          rs, wc, wr, rc, rd;
    logic [DW-1:0] d;
    int            full_n, empty_n, cnt, dout, af, ae;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(logic rs, logic wc, logic wr, logic [DW-1:0] d, logic rc,
                              logic rd, int fn, int en, int c, int dt, int af, int ae);
    vec_t v;
    v.rs = rs; v.wc = wc; v.wr = wr; v.d = d; v.rc = rc; v.rd = rd;
    v.full_n = fn; v.empty_n = en; v.cnt = c; v.dout = dt; v.af = af; v.ae = ae;
    return v;
  endfunction

  task automatic check_outs(input string tag, input int fn, input int en, input int c,
                            input int dt, input int af, input int ae);
    chk({tag, ".full_n"}, int'(o_full_n), fn);
    chk({tag, ".empty_n"}, int'(o_empty_n), en);
    chk({tag, ".count"}, int'(o_cnt), c);
    chk({tag, ".afull"}, int'(o_af), af);
    chk({tag, ".aempty"}, int'(o_ae), ae);
    if (en != 0) chk({tag, ".dout"}, int'(o_dout), dt);
  endtask

  task automatic run_random(input logic oreg, input int n);
    logic [DW-1:0] q[$];
    logic          outv;
    logic [DW-1:0] outd;
    logic          mfull_n, mempty_n, push, pop, ld, rs, wr_bias;
    int            c;
    sel = oreg;
    outv = 1'b0; outd = '0;
    drive(1, 0, 0, 0, 0, 0);
    step();
    for (int k = 0; k < n; k++) begin
      wr_bias = ((k / 40) % 2) == 0;
      rs = ($urandom_range(0, 59) == 0);
      drive(rs, $urandom_range(0, 4) != 0, wr_bias ? $urandom_range(0, 3) != 0 : $urandom_range(0, 3) == 0,
            DW'($urandom), $urandom_range(0, 4) != 0,
            wr_bias ? $urandom_range(0, 3) == 0 : $urandom_range(0, 3) != 0);
      mfull_n  = q.size() < DP;
      mempty_n = oreg ? outv : (q.size() != 0);
      push = wce & w & mfull_n;
      pop  = rce & r & mempty_n;
      step();
      if (rs) begin
        q.delete();
        outv = 1'b0;
      end else if (!oreg) begin
        if (pop) void'(q.pop_front());
        if (push) q.push_back(din);
      end else begin
        ld = (q.size() != 0) && (!outv || pop);
        if (ld) begin
          outd = q.pop_front();
          outv = 1'b1;
        end else if (pop) begin
          outv = 1'b0;
        end
        if (push) q.push_back(din);
      end
      c = q.size() + ((oreg && outv) ? 1 : 0);
      check_outs(oreg ? "rand1" : "rand0", q.size() < DP, oreg ? int'(outv) : int'(q.size() != 0),
                 c, oreg ? int'(outd) : ((q.size() != 0) ? int'(q[0]) : 0), c >= 3, c <= 1);
    end
  endtask

  initial begin
    sel = 1'b0;
    drive(1, 0, 0, 0, 0, 0);

    // Directed vectors on the OUT_REG=0 instance: fill, overflow attempt, drain, gating, reset.
    vq.push_back(mk(1, 0, 0, 8'h00, 0, 0, 1, 0, 0, 0, 0, 1));
    vq.push_back(mk(0, 1, 1, 8'h11, 0, 0, 1, 1, 1, 8'h11, 0, 1));
    vq.push_back(mk(0, 1, 1, 8'h22, 0, 0, 1, 1, 2, 8'h11, 0, 0));
    vq.push_back(mk(0, 1, 1, 8'h33, 0, 0, 1, 1, 3, 8'h11, 1, 0));
    vq.push_back(mk(0, 1, 1, 8'h44, 0, 0, 0, 1, 4, 8'h11, 1, 0));
    vq.push_back(mk(0, 1, 1, 8'h55, 0, 0, 0, 1, 4, 8'h11, 1, 0));
    vq.push_back(mk(0, 0, 0, 8'h00, 1, 1, 1, 1, 3, 8'h22, 1, 0));
    vq.push_back(mk(0, 0, 0, 8'h00, 1, 1, 1, 1, 2, 8'h33, 0, 0));
    vq.push_back(mk(0, 0, 0, 8'h00, 1, 1, 1, 1, 1, 8'h44, 0, 1));
    vq.push_back(mk(0, 0, 0, 8'h00, 1, 1, 1, 0, 0, 0, 0, 1));
    vq.push_back(mk(0, 0, 0, 8'h00, 1, 1, 1, 0, 0, 0, 0, 1));
    vq.push_back(mk(0, 1, 1, 8'h01, 0, 0, 1, 1, 1, 8'h01, 0, 1));
    vq.push_back(mk(0, 1, 1, 8'h02, 0, 0, 1, 1, 2, 8'h01, 0, 0));
    for (int i = 0; i < 5; i++)
      vq.push_back(mk(0, 0, 1, 8'h77, 0, 1, 1, 1, 2, 8'h01, 0, 0));
    vq.push_back(mk(0, 1, 1, 8'h03, 0, 0, 1, 1, 3, 8'h01, 1, 0));
    vq.push_back(mk(1, 1, 1, 8'h99, 1, 1, 1, 0, 0, 0, 0, 1));
    vq.push_back(mk(0, 1, 1, 8'hA5, 0, 0, 1, 1, 1, 8'hA5, 0, 1));
    vq.push_back(mk(0, 0, 0, 8'h00, 1, 1, 1, 0, 0, 0, 0, 1));

    foreach (vq[i]) begin
      drive(vq[i].rs, vq[i].wc, vq[i].wr, vq[i].d, vq[i].rc, vq[i].rd);
      step();
      check_outs($sformatf("vec%0d", i), vq[i].full_n, vq[i].empty_n, vq[i].cnt, vq[i].dout,
                 vq[i].af, vq[i].ae);
    end

    // Streaming at constant occupancy of 2 with simultaneous push and pop.
    drive(0, 1, 1, 8'd0, 0, 0); step();
    drive(0, 1, 1, 8'd1, 0, 0); step();
    for (int k = 0; k < 20; k++) begin
      chk("stream.dout_pre", int'(dout0), k);
      drive(0, 1, 1, DW'(k + 2), 1, 1);
      step();
      chk("stream.count", int'(cnt0), 2);
      chk("stream.full_n", int'(full_n0), 1);
    end
    drive(0, 0, 0, 0, 0, 0);

    // OUT_REG=1: one extra edge of latency through dreg.
    sel = 1'b1;
    drive(1, 0, 0, 0, 0, 0); step();
    check_outs("oreg.reset", 1, 0, 0, 0, 0, 1);
    drive(0, 1, 1, 8'h10, 0, 0); step();
    chk("oreg.lat_n.empty_n", int'(empty_n1), 0);
    chk("oreg.lat_n.count", int'(cnt1), 1);
    drive(0, 0, 0, 0, 0, 0); step();
    chk("oreg.lat_n1.empty_n", int'(empty_n1), 1);
    chk("oreg.lat_n1.dout", int'(dout1), 8'h10);

    drive(1, 0, 0, 0, 0, 0); step();
    for (int k = 0; k < 5; k++) begin
      drive(0, 1, 1, DW'(8'hC0 + k), 0, 0);
      step();
    end
    drive(0, 0, 0, 0, 0, 0);
    check_outs("oreg.full", 0, 1, 5, 8'hC0, 1, 0);
    for (int k = 0; k < 5; k++) begin
      chk("oreg.drain.empty_n", int'(empty_n1), 1);
      chk("oreg.drain.dout", int'(dout1), 8'hC0 + k);
      chk("oreg.drain.count", int'(cnt1), 5 - k);
      drive(0, 0, 0, 0, 1, 1);
      step();
    end
    drive(0, 0, 0, 0, 0, 0);
    check_outs("oreg.empty", 1, 0, 0, 0, 0, 1);

    run_random(1'b0, 400);
    run_random(1'b1, 400);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
